// File: rtl/fifo_16to8_width_conv_pkg.sv
// Shared widths and data types for the 16-to-8 width-converting FIFO.
// The word is always two bytes; the low byte leaves the FIFO first.
package fifo_pkg;
  localparam int RD_WIDTH = 8;
  localparam int RATIO    = 2;
  localparam int WR_WIDTH = RATIO * RD_WIDTH;

  typedef logic [RD_WIDTH-1:0] byte_t;
  typedef logic [WR_WIDTH-1:0] word_t;
endpackage

// File: rtl/fifo_16to8_width_conv_if.sv
// Bus bundle between a 16-bit word producer and the 8-bit byte consumer.
// wr_i pushes wr_data_i only while full_o=0; rd_i pops rd_data_o only while empty_o=0;
// strobes against the opposite flag are ignored, and both flags are sampled before the edge.
interface fifo_16to8_width_conv_if #(
  parameter int ADDR_WIDTH = 4
);
  import fifo_pkg::*;

  logic                  wr_i;
  word_t                 wr_data_i;
  logic                  rd_i;
  byte_t                 rd_data_o;
  logic                  full_o;
  logic                  empty_o;
  logic [ADDR_WIDTH+1:0] rd_count_o;

  modport master (
    output wr_i, wr_data_i, rd_i,
    input  rd_data_o, full_o, empty_o, rd_count_o
  );

  modport slave (
    input  wr_i, wr_data_i, rd_i,
    output rd_data_o, full_o, empty_o, rd_count_o
  );
endinterface

// File: rtl/fifo_16to8_width_conv_ctrl.sv
// Pointer control: word write pointer, byte read pointer, accept logic and flags.
// The read pointer counts bytes, so a slot only frees after its high byte is read.
module fifo_ctrl_wc #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_sel,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH+1:0] rd_count
);
  logic [ADDR_WIDTH:0]   w_ptr;
  logic [ADDR_WIDTH+1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_word;
  logic                  rd_en;

  assign r_word = r_ptr[ADDR_WIDTH+1:1];

  // The extra MSB on both word pointers separates a full ring from an empty one.
  assign empty = (w_ptr == r_word);
  assign full  = (w_ptr[ADDR_WIDTH] != r_word[ADDR_WIDTH]) &&
                 (w_ptr[ADDR_WIDTH-1:0] == r_word[ADDR_WIDTH-1:0]);

  assign wr_en = wr && !full;
  assign rd_en = rd && !empty;

  assign rd_count = {w_ptr, 1'b0} - r_ptr;
  assign w_addr   = w_ptr[ADDR_WIDTH-1:0];
  assign r_addr   = r_word[ADDR_WIDTH-1:0];
  assign r_sel    = r_ptr[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
    end else begin
      if (wr_en) w_ptr <= w_ptr + 1'b1;
      if (rd_en) r_ptr <= r_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/fifo_16to8_width_conv.sv
// 16-bit in / 8-bit out synchronous FIFO, first-word-fall-through on the read side.
// Holds the word storage and the byte mux; pointers and flags live in fifo_ctrl_wc.
module fifo_16to8_width_conv
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fifo_16to8_width_conv_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  word_t                 mem [DEPTH];
  word_t                 head;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_sel;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH+1:0] rd_count;

  fifo_ctrl_wc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ctrl (
    .clk      (clk_i),
    .rst      (rst_i),
    .wr       (bus.wr_i),
    .rd       (bus.rd_i),
    .wr_en    (wr_en),
    .w_addr   (w_addr),
    .r_addr   (r_addr),
    .r_sel    (r_sel),
    .full     (full),
    .empty    (empty),
    .rd_count (rd_count)
  );

  // Storage is deliberately not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[w_addr] <= bus.wr_data_i;
  end

  assign head          = mem[r_addr];
  assign bus.rd_data_o = r_sel ? head[WR_WIDTH-1:RD_WIDTH] : head[RD_WIDTH-1:0];
  assign bus.full_o     = full;
  assign bus.empty_o    = empty;
  assign bus.rd_count_o = rd_count;
endmodule

// File: tb/tb_fifo_16to8_width_conv.sv
// Directed bench for fifo_16to8_width_conv with a byte scoreboard and flag model.
module tb_fifo_16to8_width_conv;
  localparam int AW    = 4;
  localparam int BYTES = 2 * (2 ** AW);

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] exp_q[$];

  fifo_16to8_width_conv_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_16to8_width_conv #(.ADDR_WIDTH(AW)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: occupied word slots = ceil(bytes/2); full when all slots are taken
  function automatic logic m_full();
    return ((exp_q.size() + 1) / 2) == (2 ** AW);
  endfunction

  function automatic logic m_empty();
    return exp_q.size() == 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ":empty"}, 32'(bus.empty_o), 32'(m_empty()));
    chk({tag, ":full"}, 32'(bus.full_o), 32'(m_full()));
    chk({tag, ":count"}, 32'(bus.rd_count_o), 32'(exp_q.size()));
    if (exp_q.size() > 0) chk({tag, ":data"}, 32'(bus.rd_data_o), 32'(exp_q[0]));
  endtask

  // driver: apply strobes for one clock, update the model with pre-edge flags, check at negedge
  task automatic step(input logic w, input logic [15:0] d, input logic r, input string tag);
    logic acc_w;
    logic acc_r;
    acc_w = w && !m_full();
    acc_r = r && !m_empty();
    bus.wr_i      = w;
    bus.wr_data_i = d;
    bus.rd_i      = r;
    @(posedge clk);
    if (acc_r) void'(exp_q.pop_front());
    if (acc_w) begin
      exp_q.push_back(d[7:0]);
      exp_q.push_back(d[15:8]);
    end
    #1;
    bus.wr_i = 1'b0;
    bus.rd_i = 1'b0;
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    exp_q.delete();
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 200) begin
      step(1'b0, 16'h0, 1'b1, tag);
      guard++;
    end
    chk({tag, ":drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int written;
    int guard;
    logic w;
    logic r;
    logic [15:0] d;

    rst           = 1'b1;
    bus.wr_i      = 1'b0;
    bus.wr_data_i = 16'h0;
    bus.rd_i      = 1'b0;

    // reset state
    do_reset(2);
    chk("rst_empty", 32'(bus.empty_o), 32'd1);
    chk("rst_full", 32'(bus.full_o), 32'd0);
    chk("rst_count", 32'(bus.rd_count_o), 32'd0);

    // single word, low byte first
    step(1'b1, 16'hBEEF, 1'b0, "beef_wr");
    chk("beef_lo", 32'(bus.rd_data_o), 32'h0EF);
    chk("beef_cnt2", 32'(bus.rd_count_o), 32'd2);
    step(1'b0, 16'h0, 1'b1, "beef_rd0");
    chk("beef_hi", 32'(bus.rd_data_o), 32'h0BE);
    chk("beef_cnt1", 32'(bus.rd_count_o), 32'd1);
    chk("beef_not_empty", 32'(bus.empty_o), 32'd0);
    step(1'b0, 16'h0, 1'b1, "beef_rd1");
    chk("beef_empty", 32'(bus.empty_o), 32'd1);
    chk("beef_cnt0", 32'(bus.rd_count_o), 32'd0);

    // fill to full, overflow write ignored
    for (int i = 0; i < 2 ** AW; i++) begin
      d = {8'(2 * i + 1), 8'(2 * i)};
      step(1'b1, d, 1'b0, "fill");
    end
    chk("fill_full", 32'(bus.full_o), 32'd1);
    chk("fill_cnt", 32'(bus.rd_count_o), 32'(BYTES));
    step(1'b1, 16'hDEAD, 1'b0, "overflow");
    chk("ovf_cnt", 32'(bus.rd_count_o), 32'(BYTES));
    chk("ovf_head", 32'(bus.rd_data_o), 32'h000);

    // full: low-byte read plus write in one cycle, write dropped
    step(1'b1, 16'hCAFE, 1'b1, "full_rw");
    chk("full_rw_full", 32'(bus.full_o), 32'd1);
    chk("full_rw_cnt", 32'(bus.rd_count_o), 32'(BYTES - 1));
    step(1'b0, 16'h0, 1'b1, "full_rd_hi");
    chk("full_cleared", 32'(bus.full_o), 32'd0);
    chk("full_cleared_cnt", 32'(bus.rd_count_o), 32'(BYTES - 2));
    chk("next_byte", 32'(bus.rd_data_o), 32'h002);
    drain("drain_fill");

    // empty: read and write together, read dropped
    step(1'b1, 16'h1234, 1'b1, "empty_rw");
    chk("empty_rw_data", 32'(bus.rd_data_o), 32'h034);
    chk("empty_rw_cnt", 32'(bus.rd_count_o), 32'd2);
    drain("drain_1234");

    // interleaved stream wrapping the pointers
    written = 0;
    guard   = 0;
    while (written < 40 && guard < 2000) begin
      w = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      d = 16'($urandom_range(0, 65535));
      if (w && !m_full()) written++;
      step(w, d, r, "stream");
      guard++;
    end
    chk("stream_words", 32'(written), 32'd40);
    drain("drain_stream");

    // reset mid-transfer discards everything, including a half-read word
    for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h1111 * (i + 1)), 1'b0, "pre_rst_wr");
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, "pre_rst_rd");
    chk("pre_rst_cnt", 32'(bus.rd_count_o), 32'd3);
    bus.wr_i      = 1'b1;
    bus.wr_data_i = 16'h7777;
    bus.rd_i      = 1'b1;
    do_reset(1);
    bus.wr_i = 1'b0;
    bus.rd_i = 1'b0;
    chk("mid_rst_empty", 32'(bus.empty_o), 32'd1);
    chk("mid_rst_full", 32'(bus.full_o), 32'd0);
    chk("mid_rst_cnt", 32'(bus.rd_count_o), 32'd0);
    step(1'b1, 16'hA55A, 1'b0, "a55a_wr");
    chk("a55a_lo", 32'(bus.rd_data_o), 32'h05A);
    step(1'b0, 16'h0, 1'b1, "a55a_rd0");
    chk("a55a_hi", 32'(bus.rd_data_o), 32'h0A5);
    step(1'b0, 16'h0, 1'b1, "a55a_rd1");
    chk("a55a_empty", 32'(bus.empty_o), 32'd1);

    // underflow read leaves state untouched
    step(1'b0, 16'h0, 1'b1, "underflow");
    chk("uflow_cnt", 32'(bus.rd_count_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
